mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Initiator side of the data-memory port: drives the memory's write strobe, read strobe, address and write data, and captures its read data.
- Sits between the MEM pipeline stage and the 2048x16 data memory.
- Sequences 16-bit load/store, stack push/pop, and 32-bit push/pop (CALL/RET of PC) as one or two word accesses.
- Owns the stack pointer.

Parameters:
ADDR_W, 11, memory address width
DATA_W, 16, memory word width
STACK_BASE, 2047, SP reset value and highest stack address
STACK_LIMIT, 1024, lowest address the stack may write (guard only)

Ports:
Clk  in  1  clock; all state updates on posedge
Rst  in  1  synchronous, active-high reset
Req  in  1  operation request; sampled only in IDLE
Op  in  3  000 LOAD, 001 STORE, 010 PUSH, 011 POP, 100 PUSH32, 101 POP32, 110/111 NOP
EffAddr  in  ADDR_W  address for LOAD/STORE
WrData  in  2*DATA_W  STORE/PUSH use [15:0]; PUSH32 uses all 32 bits
Busy  out  1  high whenever state != IDLE
Done  out  1  one-cycle completion pulse
RdData  out  2*DATA_W  LOAD/POP: {16'b0, word}; POP32: {high, low}; held until next Done
SP  out  ADDR_W  current stack pointer
StackErr  out  1  sticky guard error (tied 0 without the optional feature)
MemeWrite  out  1  memory write strobe
MemeRead  out  1  memory read strobe
Addr  out  ADDR_W  memory address
DataToMem  out  DATA_W  memory write data
DataFromMem  in  DATA_W  memory read data, combinational while MemeRead=1

Behaviour:
- Reset (posedge with Rst=1):
  - state=IDLE, SP=STACK_BASE, RdData=0, StackErr=0.
  - Busy, Done, MemeWrite and MemeRead are all 0.
  - Addr and DataToMem are 0.
- Reset mid-operation: same result at that edge; the operation is abandoned. A write already driven in the prior cycle has completed at that cycle's negedge.
- FSM states: IDLE, ACC1, ACC2, DONE.
  - IDLE: Req=1 latches Op, EffAddr and WrData, then goes to ACC1. Req while Busy is ignored; no queuing.
  - ACC1: drives the first word access. Next state is ACC2 for PUSH32/POP32, DONE otherwise.
  - ACC2: drives the second word access, then DONE.
  - DONE: Done=1 for one cycle, then IDLE.
- Latency: single-word op has Done 2 cycles after the accepting edge; two-word op has Done 3 cycles after. NOP goes ACC1 -> DONE with no strobes.
- Memory side: Addr, DataToMem and strobes are combinational from the registered state and latched operands, so they are stable for the full access cycle. Memory writes at the negedge.
  - MemeRead=1 only in read access cycles and is exactly 0 otherwise; the memory outputs x when it is not 1.
  - At most one strobe is high per cycle.
- Read data: DataFromMem is captured at the posedge ending each read cycle.
- Word accesses (SP arithmetic is modulo 2^ADDR_W; SP updates at the edge ending the final access):
  - LOAD: read EffAddr. STORE: write WrData[15:0] to EffAddr. SP unchanged.
  - PUSH: write WrData[15:0] at SP; SP<=SP-1.
  - POP: read SP+1; SP<=SP+1.
  - PUSH32: ACC1 writes WrData[31:16] at SP; ACC2 writes WrData[15:0] at SP-1; SP<=SP-2.
  - POP32: ACC1 reads low at SP+1; ACC2 reads high at SP+2; SP<=SP+2.
- Wrap-around (no guard): PUSH at SP=0 writes address 0 and SP becomes 2047.

Optional Feature:
- STACK_GUARD_EN defined:
  - Each stack op is checked when accepted.
  - The op faults if:
    - a push would write below STACK_LIMIT (PUSH: SP<STACK_LIMIT; PUSH32: SP-1<STACK_LIMIT or SP<STACK_LIMIT), or
    - a pop would read above STACK_BASE (POP: SP+1>STACK_BASE; POP32: SP+2>STACK_BASE), with the comparison done without wrap.
  - A faulting op issues no strobes, leaves SP unchanged and RdData unchanged, and sets StackErr=1 until Rst.
  - Done still pulses at the normal latency.
- STACK_GUARD_EN not defined: no checks, modular wrap, StackErr constant 0.

Test Plan:
1. Reset, then STORE EffAddr=5 WrData=0x1234, then LOAD 5 -> one MemeWrite cycle at Addr=5; Done 2 cycles after accept; RdData=0x00001234; SP=2047 throughout.
2. PUSH 0xAAAA then POP -> writes Mem[2047]; SP 2046 then 2047; POP reads Addr=2047; RdData=0x0000AAAA.
3. PUSH32 0xDEADBEEF then POP32 -> Mem[2047]=0xDEAD, Mem[2046]=0xBEEF; SP 2045 then 2047; RdData=0xDEADBEEF; Done 3 cycles after accept; Busy high 3 cycles.
4. Req held high during PUSH32 with Op=STORE -> ignored until IDLE, then accepted once; MemeRead never 1 during write cycles.
5. Rst asserted in ACC2 of PUSH32 -> next edge IDLE, SP=2047, no Done, no further strobes.
6. STACK_GUARD_EN with POP at SP=2047 -> no MemeRead, SP=2047, StackErr=1, Done pulses. Without the macro, PUSH at SP=0 -> Addr=0 written, SP=2047.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Bundle of the pipeline-side request signals and the data-memory strobe/
// address/data signals seen by the memory access controller.
// The controller takes the slave view; the MEM stage plus memory take master.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);

  logic                  Req;
  logic [2:0]            Op;
  logic [ADDR_W-1:0]     EffAddr;
  logic [2*DATA_W-1:0]   WrData;
  logic                  Busy;
  logic                  Done;
  logic [2*DATA_W-1:0]   RdData;
  logic [ADDR_W-1:0]     SP;
  logic                  StackErr;
  logic                  MemeWrite;
  logic                  MemeRead;
  logic [ADDR_W-1:0]     Addr;
  logic [DATA_W-1:0]     DataToMem;
  logic [DATA_W-1:0]     DataFromMem;

  modport master (
    output Req, Op, EffAddr, WrData, DataFromMem,
    input  Busy, Done, RdData, SP, StackErr,
    input  MemeWrite, MemeRead, Addr, DataToMem
  );

  modport slave (
    input  Req, Op, EffAddr, WrData, DataFromMem,
    output Busy, Done, RdData, SP, StackErr,
    output MemeWrite, MemeRead, Addr, DataToMem
  );

endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: turns one MEM-stage request into one or two
// 16-bit word accesses (load/store, push/pop, 32-bit push/pop of the PC) and
// owns the stack pointer.
// Optional feature: define STACK_GUARD_EN to reject pushes below STACK_LIMIT
// and pops above STACK_BASE, flagged through a sticky StackErr. Without it the
// stack pointer wraps modulo 2^ADDR_W and StackErr is tied low.
module mem_access_ctrl #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 16,
`ifdef STACK_GUARD_EN
  parameter int STACK_LIMIT = 1024,
`endif
  parameter int STACK_BASE  = 2047
) (
  input logic              Clk,
  input logic              Rst,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} stateT;

  localparam logic [2:0] OpLoad   = 3'b000;
  localparam logic [2:0] OpStore  = 3'b001;
  localparam logic [2:0] OpPush   = 3'b010;
  localparam logic [2:0] OpPop    = 3'b011;
  localparam logic [2:0] OpPush32 = 3'b100;
  localparam logic [2:0] OpPop32  = 3'b101;

  localparam logic [ADDR_W-1:0] SpOne   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] SpTwo   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] SpReset = ADDR_W'(STACK_BASE);

  stateT                 state;
  stateT                 nextState;
  logic [2:0]            opReg;
  logic [ADDR_W-1:0]     addrReg;
  logic [2*DATA_W-1:0]   wrReg;
  logic [2*DATA_W-1:0]   rdReg;
  logic [DATA_W-1:0]     lowReg;
  logic [ADDR_W-1:0]     spReg;
  logic                  faultReg;
  logic                  errReg;
  logic                  faultNow;

  logic                  accWrite;
  logic                  accRead;
  logic [ADDR_W-1:0]     accAddr;
  logic [DATA_W-1:0]     accData;
  logic                  spLoad;
  logic [ADDR_W-1:0]     spNext;

`ifdef STACK_GUARD_EN
  localparam logic [ADDR_W+1:0] LimitExt = (ADDR_W+2)'(STACK_LIMIT);
  localparam logic [ADDR_W+1:0] BaseExt  = (ADDR_W+2)'(STACK_BASE);
  localparam logic [ADDR_W+1:0] ExtOne   = (ADDR_W+2)'(1);
  localparam logic [ADDR_W+1:0] ExtTwo   = (ADDR_W+2)'(2);

  logic [ADDR_W+1:0] spExt;

  assign spExt = {2'b00, spReg};

  // Judge the incoming stack op against the bounds in a wider, unwrapped domain;
  // a PUSH32 writing at SP-1 faults as soon as SP is at or below the limit.
  always_comb begin
    faultNow = 1'b0;
    case (bus.Op)
      OpPush:   faultNow = (spExt < LimitExt);
      OpPush32: faultNow = (spExt <= LimitExt);
      OpPop:    faultNow = ((spExt + ExtOne) > BaseExt);
      OpPop32:  faultNow = ((spExt + ExtTwo) > BaseExt);
      default:  faultNow = 1'b0;
    endcase
  end
`else
  assign faultNow = 1'b0;
`endif

  // Next-state and memory-side decode: every strobe, address and data word is
  // derived from the registered state and latched operands only.
  always_comb begin
    nextState = state;
    accWrite  = 1'b0;
    accRead   = 1'b0;
    accAddr   = '0;
    accData   = '0;
    spLoad    = 1'b0;
    spNext    = spReg;
    case (state)
      IDLE: begin
        if (bus.Req) begin
          nextState = ACC1;
        end
      end
      ACC1: begin
        if ((opReg == OpPush32) || (opReg == OpPop32)) begin
          nextState = ACC2;
        end else begin
          nextState = DONE;
        end
        if (!faultReg) begin
          case (opReg)
            OpLoad: begin
              accRead = 1'b1;
              accAddr = addrReg;
            end
            OpStore: begin
              accWrite = 1'b1;
              accAddr  = addrReg;
              accData  = wrReg[DATA_W-1:0];
            end
            OpPush: begin
              accWrite = 1'b1;
              accAddr  = spReg;
              accData  = wrReg[DATA_W-1:0];
              spLoad   = 1'b1;
              spNext   = spReg - SpOne;
            end
            OpPop: begin
              accRead = 1'b1;
              accAddr = spReg + SpOne;
              spLoad  = 1'b1;
              spNext  = spReg + SpOne;
            end
            OpPush32: begin
              accWrite = 1'b1;
              accAddr  = spReg;
              accData  = wrReg[2*DATA_W-1:DATA_W];
            end
            OpPop32: begin
              accRead = 1'b1;
              accAddr = spReg + SpOne;
            end
            default: begin
              accWrite = 1'b0;
            end
          endcase
        end
      end
      ACC2: begin
        nextState = DONE;
        if (!faultReg) begin
          case (opReg)
            OpPush32: begin
              accWrite = 1'b1;
              accAddr  = spReg - SpOne;
              accData  = wrReg[DATA_W-1:0];
              spLoad   = 1'b1;
              spNext   = spReg - SpTwo;
            end
            OpPop32: begin
              accRead = 1'b1;
              accAddr = spReg + SpTwo;
              spLoad  = 1'b1;
              spNext  = spReg + SpTwo;
            end
            default: begin
              accRead = 1'b0;
            end
          endcase
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // State register plus operand latching, stack pointer update and read-data
  // capture at the edge that ends each read cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      opReg    <= '0;
      addrReg  <= '0;
      wrReg    <= '0;
      rdReg    <= '0;
      lowReg   <= '0;
      spReg    <= SpReset;
      faultReg <= 1'b0;
      errReg   <= 1'b0;
    end else begin
      state <= nextState;
      if ((state == IDLE) && bus.Req) begin
        opReg    <= bus.Op;
        addrReg  <= bus.EffAddr;
        wrReg    <= bus.WrData;
        faultReg <= faultNow;
        if (faultNow) begin
          errReg <= 1'b1;
        end
      end
      if (spLoad) begin
        spReg <= spNext;
      end
      if (accRead) begin
        if ((state == ACC1) && (opReg == OpPop32)) begin
          lowReg <= bus.DataFromMem;
        end else if (state == ACC2) begin
          rdReg <= {bus.DataFromMem, lowReg};
        end else begin
          rdReg <= {{DATA_W{1'b0}}, bus.DataFromMem};
        end
      end
    end
  end

  assign bus.Busy      = (state != IDLE);
  assign bus.Done      = (state == DONE);
  assign bus.RdData    = rdReg;
  assign bus.SP        = spReg;
  assign bus.StackErr  = errReg;
  assign bus.MemeWrite = accWrite;
  assign bus.MemeRead  = accRead;
  assign bus.Addr      = accAddr;
  assign bus.DataToMem = accData;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a behavioural 2048x16 memory, an
// access monitor, and a word-level reference model of memory, SP and RdData.
// Build with STACK_GUARD_EN defined to exercise the guarded stack variant.
module tb_mem_access_ctrl;

  localparam int AW    = 11;
  localparam int DW    = 16;
  localparam int DEPTH = 2048;

  logic Clk;
  logic Rst;

  mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_access_ctrl dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Free-running clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory the controller talks to: writes at the negedge, reads combinational.
  logic [DW-1:0] ram [DEPTH];
  assign bus.DataFromMem = bus.MemeRead ? ram[bus.Addr] : 'x;

  always @(negedge Clk) begin
    if (bus.MemeWrite) ram[bus.Addr] = bus.DataToMem;
  end

  // Access monitor: records every strobed cycle and counts Done pulses.
  bit            accW [$];
  logic [AW-1:0] accA [$];
  logic [DW-1:0] accD [$];
  int            bothStrobes = 0;
  int            donePulses  = 0;

  always @(negedge Clk) begin
    if (bus.MemeWrite || bus.MemeRead) begin
      accW.push_back(bus.MemeWrite);
      accA.push_back(bus.Addr);
      accD.push_back(bus.DataToMem);
    end
    if (bus.MemeWrite && bus.MemeRead) bothStrobes++;
    if (bus.Done) donePulses++;
  end

  // Reference model state and the expected access list of the current op.
  logic [DW-1:0] modelMem [DEPTH];
  int            modelSp;
  logic [31:0]   modelRd;
  bit            modelErr;
  bit            expW [$];
  logic [AW-1:0] expA [$];
  logic [DW-1:0] expD [$];
  int            expLat;

  task automatic expectWrite(input int a, input logic [DW-1:0] d);
    expW.push_back(1'b1);
    expA.push_back(AW'(a));
    expD.push_back(d);
    modelMem[a] = d;
  endtask

  task automatic expectRead(input int a, output logic [DW-1:0] d);
    expW.push_back(1'b0);
    expA.push_back(AW'(a));
    expD.push_back('0);
    d = modelMem[a];
  endtask

  task automatic modelOp(input logic [2:0] op, input logic [AW-1:0] ea, input logic [31:0] wd);
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    bit fault;
    expLat = (op == 3'd4 || op == 3'd5) ? 3 : 2;
    fault = 1'b0;
`ifdef STACK_GUARD_EN
    case (op)
      3'd2:    fault = (modelSp < 1024);
      3'd3:    fault = (modelSp + 1 > 2047);
      3'd4:    fault = (modelSp - 1 < 1024);
      3'd5:    fault = (modelSp + 2 > 2047);
      default: fault = 1'b0;
    endcase
    if (fault) modelErr = 1'b1;
`endif
    if (!fault) begin
      case (op)
        3'd0: begin
          expectRead(int'(ea), lo);
          modelRd = {16'h0000, lo};
        end
        3'd1: expectWrite(int'(ea), wd[15:0]);
        3'd2: begin
          expectWrite(modelSp, wd[15:0]);
          modelSp = (modelSp - 1) & (DEPTH - 1);
        end
        3'd3: begin
          modelSp = (modelSp + 1) & (DEPTH - 1);
          expectRead(modelSp, lo);
          modelRd = {16'h0000, lo};
        end
        3'd4: begin
          expectWrite(modelSp, wd[31:16]);
          expectWrite((modelSp - 1) & (DEPTH - 1), wd[15:0]);
          modelSp = (modelSp - 2) & (DEPTH - 1);
        end
        3'd5: begin
          expectRead((modelSp + 1) & (DEPTH - 1), lo);
          expectRead((modelSp + 2) & (DEPTH - 1), hi);
          modelRd = {hi, lo};
          modelSp = (modelSp + 2) & (DEPTH - 1);
        end
        default: begin
        end
      endcase
    end
  endtask

  // One request, waited on with a bounded loop, then compared to the model.
  task automatic runOp(input logic [2:0] op, input logic [AW-1:0] ea, input logic [31:0] wd, input string tag);
    int n;
    int busyCnt;
    bit seen;
    expW.delete(); expA.delete(); expD.delete();
    modelOp(op, ea, wd);
    @(negedge Clk);
    accW.delete(); accA.delete(); accD.delete();
    bus.Req = 1'b1; bus.Op = op; bus.EffAddr = ea; bus.WrData = wd;
    @(posedge Clk);
    #1;
    bus.Req = 1'b0; bus.Op = 3'($urandom); bus.EffAddr = AW'($urandom); bus.WrData = $urandom;
    n = 0; busyCnt = 0; seen = 1'b0;
    while (!seen && n < 8) begin
      @(negedge Clk);
      n++;
      if (bus.Busy) busyCnt++;
      seen = bus.Done;
    end
    checks++;
    if (!seen || n != expLat) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d cycles (done seen %0b), expected %0d", tag, n, seen, expLat);
    end
    checks++;
    if (busyCnt != n) begin
      errors++;
      $display("[TB] FAIL %s busy: high %0d of %0d cycles, expected all", tag, busyCnt, n);
    end
    checks++;
    if (accW.size() != expW.size()) begin
      errors++;
      $display("[TB] FAIL %s access count: got %0d, expected %0d", tag, accW.size(), expW.size());
    end else begin
      for (int i = 0; i < expW.size(); i++) begin
        checks++;
        if (accW[i] !== expW[i] || accA[i] !== expA[i] || (expW[i] && accD[i] !== expD[i])) begin
          errors++;
          $display("[TB] FAIL %s access %0d: got wr=%0b addr=%0d data=%h, expected wr=%0b addr=%0d data=%h",
                   tag, i, accW[i], accA[i], accD[i], expW[i], expA[i], expD[i]);
        end
      end
    end
    checks++;
    if (bus.RdData !== modelRd) begin
      errors++;
      $display("[TB] FAIL %s rddata: got %h, expected %h", tag, bus.RdData, modelRd);
    end
    checks++;
    if (bus.SP !== AW'(modelSp)) begin
      errors++;
      $display("[TB] FAIL %s sp: got %0d, expected %0d", tag, bus.SP, modelSp);
    end
    checks++;
    if (bus.StackErr !== modelErr) begin
      errors++;
      $display("[TB] FAIL %s stackerr: got %b, expected %b", tag, bus.StackErr, modelErr);
    end
    checks++;
    if (bothStrobes != 0) begin
      errors++;
      $display("[TB] FAIL %s strobes: %0d cycles with both strobes, expected 0", tag, bothStrobes);
    end
    @(negedge Clk);
    checks++;
    if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s after done: got done=%b busy=%b, expected 0 0", tag, bus.Done, bus.Busy);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    bus.Req = 1'b0; bus.Op = 3'd0; bus.EffAddr = '0; bus.WrData = '0;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({bus.Busy, bus.Done, bus.MemeWrite, bus.MemeRead} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset flags: got busy/done/wr/rd=%b, expected 0000",
               {bus.Busy, bus.Done, bus.MemeWrite, bus.MemeRead});
    end
    checks++;
    if (bus.Addr !== 11'd0 || bus.DataToMem !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset bus: got addr=%0d data=%h, expected 0 0", bus.Addr, bus.DataToMem);
    end
    checks++;
    if (bus.SP !== 11'd2047 || bus.RdData !== 32'd0 || bus.StackErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset regs: got sp=%0d rd=%h err=%b, expected 2047 0 0", bus.SP, bus.RdData, bus.StackErr);
    end
    @(negedge Clk);
    Rst = 1'b0;
    modelSp = 2047; modelRd = '0; modelErr = 1'b0;
  endtask

  task automatic test_load_store();
    runOp(3'd1, 11'd5, 32'h0000_1234, "store5");
    runOp(3'd0, 11'd5, 32'h0, "load5");
    checks++;
    if (bus.RdData !== 32'h0000_1234 || bus.SP !== 11'd2047) begin
      errors++;
      $display("[TB] FAIL load5 direct: got rd=%h sp=%0d, expected 00001234 2047", bus.RdData, bus.SP);
    end
  endtask

  task automatic test_stack();
    runOp(3'd2, 11'd0, 32'h0000_AAAA, "push");
    checks++;
    if (bus.SP !== 11'd2046) begin
      errors++;
      $display("[TB] FAIL push sp: got %0d, expected 2046", bus.SP);
    end
    runOp(3'd3, 11'd0, 32'h0, "pop");
    checks++;
    if (bus.RdData !== 32'h0000_AAAA || bus.SP !== 11'd2047) begin
      errors++;
      $display("[TB] FAIL pop direct: got rd=%h sp=%0d, expected 0000aaaa 2047", bus.RdData, bus.SP);
    end
    runOp(3'd4, 11'd0, 32'hDEAD_BEEF, "push32");
    checks++;
    if (bus.SP !== 11'd2045 || ram[2047] !== 16'hDEAD || ram[2046] !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL push32 direct: got sp=%0d m2047=%h m2046=%h, expected 2045 dead beef",
               bus.SP, ram[2047], ram[2046]);
    end
    runOp(3'd5, 11'd0, 32'h0, "pop32");
    checks++;
    if (bus.RdData !== 32'hDEAD_BEEF || bus.SP !== 11'd2047) begin
      errors++;
      $display("[TB] FAIL pop32 direct: got rd=%h sp=%0d, expected deadbeef 2047", bus.RdData, bus.SP);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    int n;
    int reads;
    logic [31:0] wd1;
    logic [31:0] wd2;
    logic [AW-1:0] ea2;
    wd1 = $urandom; wd2 = $urandom; ea2 = AW'($urandom_range(0, 1000));
    expW.delete(); expA.delete(); expD.delete();
    modelOp(3'd4, 11'd0, wd1);
    modelOp(3'd1, ea2, wd2);
    @(negedge Clk);
    accW.delete(); accA.delete(); accD.delete();
    d0 = donePulses;
    bus.Req = 1'b1; bus.Op = 3'd4; bus.EffAddr = AW'($urandom); bus.WrData = wd1;
    @(posedge Clk);
    #1;
    bus.Op = 3'd1; bus.EffAddr = ea2; bus.WrData = wd2;
    repeat (4) @(posedge Clk);
    #1;
    bus.Req = 1'b0;
    n = 0;
    while ((donePulses - d0) < 2 && n < 10) begin
      @(negedge Clk);
      n++;
    end
    repeat (4) @(negedge Clk);
    checks++;
    if (donePulses - d0 != 2) begin
      errors++;
      $display("[TB] FAIL held-req done count: got %0d, expected 2", donePulses - d0);
    end
    reads = 0;
    foreach (accW[i]) if (!accW[i]) reads++;
    checks++;
    if (reads != 0) begin
      errors++;
      $display("[TB] FAIL held-req reads: got %0d read cycles, expected 0", reads);
    end
    checks++;
    if (accW.size() != expW.size()) begin
      errors++;
      $display("[TB] FAIL held-req access count: got %0d, expected %0d", accW.size(), expW.size());
    end else begin
      for (int i = 0; i < expW.size(); i++) begin
        checks++;
        if (accW[i] !== expW[i] || accA[i] !== expA[i] || accD[i] !== expD[i]) begin
          errors++;
          $display("[TB] FAIL held-req access %0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                   i, accA[i], accD[i], expA[i], expD[i]);
        end
      end
    end
    checks++;
    if (bus.SP !== AW'(modelSp)) begin
      errors++;
      $display("[TB] FAIL held-req sp: got %0d, expected %0d", bus.SP, modelSp);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    logic [31:0] wd;
    wd = $urandom;
    expW.delete(); expA.delete(); expD.delete();
    modelOp(3'd4, 11'd0, wd);
    @(negedge Clk);
    accW.delete(); accA.delete(); accD.delete();
    d0 = donePulses;
    bus.Req = 1'b1; bus.Op = 3'd4; bus.EffAddr = '0; bus.WrData = wd;
    @(posedge Clk);
    #1;
    bus.Req = 1'b0;
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    modelSp = 2047; modelRd = '0; modelErr = 1'b0;
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.SP !== 11'd2047 || bus.RdData !== 32'd0) begin
      errors++;
      $display("[TB] FAIL mid-reset state: got busy=%b done=%b sp=%0d rd=%h, expected 0 0 2047 0",
               bus.Busy, bus.Done, bus.SP, bus.RdData);
    end
    repeat (5) @(negedge Clk);
    checks++;
    if (donePulses != d0) begin
      errors++;
      $display("[TB] FAIL mid-reset done: got %0d pulses, expected 0", donePulses - d0);
    end
    checks++;
    if (accW.size() != expW.size()) begin
      errors++;
      $display("[TB] FAIL mid-reset accesses: got %0d, expected %0d", accW.size(), expW.size());
    end
  endtask

`ifdef STACK_GUARD_EN
  task automatic test_guard();
    runOp(3'd3, 11'd0, 32'h0, "guard-pop");
    checks++;
    if (bus.StackErr !== 1'b1 || bus.SP !== 11'd2047) begin
      errors++;
      $display("[TB] FAIL guard-pop direct: got err=%b sp=%0d, expected 1 2047", bus.StackErr, bus.SP);
    end
  endtask
`else
  task automatic test_wrap();
    runOp(3'd3, 11'd0, 32'h0, "wrap-pop");
    checks++;
    if (bus.SP !== 11'd0) begin
      errors++;
      $display("[TB] FAIL wrap-pop sp: got %0d, expected 0", bus.SP);
    end
    runOp(3'd2, 11'd0, 32'h0000_5A5A, "wrap-push");
    checks++;
    if (bus.SP !== 11'd2047 || ram[0] !== 16'h5A5A) begin
      errors++;
      $display("[TB] FAIL wrap-push direct: got sp=%0d m0=%h, expected 2047 5a5a", bus.SP, ram[0]);
    end
  endtask
`endif

  task automatic test_random();
    logic [2:0] op;
    for (int k = 0; k < 60; k++) begin
      op = 3'($urandom_range(0, 7));
      runOp(op, AW'($urandom), $urandom, $sformatf("rand%0d_op%0d", k, op));
    end
  endtask

  // Global hang guard.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = DW'($urandom);
      ram[i] = v;
      modelMem[i] = v;
    end
    modelSp = 2047; modelRd = '0; modelErr = 1'b0;
    test_reset();
    test_load_store();
    test_stack();
    test_back_to_back();
    test_reset_mid();
`ifdef STACK_GUARD_EN
    test_guard();
`else
    test_wrap();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
